// File: rtl/sram_arbiter.sv
// Two-port SRAM-like bus arbiter: instruction and data masters share one
// downstream port, with a single outstanding transaction at a time.
module sram_arbiter #(
  parameter int PRIO_RR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   owner_nxt;
  logic   last_grant;
  logic   last_nxt;
  logic   pick;
  logic   req_c;
  logic   aok_c;
  logic   dok_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
    end
  end

  // owner encoding: 0 = inst, 1 = data
  always_comb begin
    pick = data_sram_req;
    if (inst_sram_req && data_sram_req) begin
      pick = (PRIO_RR != 0) ? ~last_grant : 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_grant;
    req_c     = 1'b0;
    aok_c     = 1'b0;
    dok_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (inst_sram_req || data_sram_req) begin
          owner_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        req_c = 1'b1;
        if (mem_addr_ok) begin
          aok_c     = 1'b1;
          last_nxt  = owner;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          dok_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs are forced quiet while reset is held
  assign mem_req           = req_c & ~reset;
  assign inst_sram_addr_ok = aok_c & ~owner & ~reset;
  assign data_sram_addr_ok = aok_c & owner & ~reset;
  assign inst_sram_data_ok = dok_c & ~owner & ~reset;
  assign data_sram_data_ok = dok_c & owner & ~reset;

  assign mem_wr    = owner ? data_sram_wr    : 1'b0;
  assign mem_size  = owner ? data_sram_size  : 2'b10;
  assign mem_wstrb = owner ? data_sram_wstrb : 4'b0000;
  assign mem_addr  = owner ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = owner ? data_sram_wdata : 32'h0;

  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: fixed-priority (g_dut[0]) and round-robin
// (g_dut[1]) instances, directed scenarios plus a random transaction model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst     [2];
  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic        i_aok   [2];
  logic        i_dok   [2];
  logic [31:0] i_rdata [2];
  logic        d_req   [2];
  logic        d_wr    [2];
  logic [1:0]  d_size  [2];
  logic [3:0]  d_wstrb [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_aok   [2];
  logic        d_dok   [2];
  logic [31:0] d_rdata [2];
  logic        m_req   [2];
  logic        m_wr    [2];
  logic [1:0]  m_size  [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_aok   [2];
  logic        m_dok   [2];
  logic [31:0] m_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(.PRIO_RR(g)) dut (
      .clk               (clk),
      .reset             (rst[g]),
      .inst_sram_req     (i_req[g]),
      .inst_sram_addr    (i_addr[g]),
      .inst_sram_addr_ok (i_aok[g]),
      .inst_sram_data_ok (i_dok[g]),
      .inst_sram_rdata   (i_rdata[g]),
      .data_sram_req     (d_req[g]),
      .data_sram_wr      (d_wr[g]),
      .data_sram_size    (d_size[g]),
      .data_sram_wstrb   (d_wstrb[g]),
      .data_sram_addr    (d_addr[g]),
      .data_sram_wdata   (d_wdata[g]),
      .data_sram_addr_ok (d_aok[g]),
      .data_sram_data_ok (d_dok[g]),
      .data_sram_rdata   (d_rdata[g]),
      .mem_req           (m_req[g]),
      .mem_wr            (m_wr[g]),
      .mem_size          (m_size[g]),
      .mem_wstrb         (m_wstrb[g]),
      .mem_addr          (m_addr[g]),
      .mem_wdata         (m_wdata[g]),
      .mem_addr_ok       (m_aok[g]),
      .mem_data_ok       (m_dok[g]),
      .mem_rdata         (m_rdata[g])
    );
  end

  task automatic raise_inst(input int d);
    i_req[d]  = 1'b1;
    i_addr[d] = $urandom;
  endtask

  task automatic raise_data(input int d);
    d_req[d]   = 1'b1;
    d_wr[d]    = 1'($urandom_range(0, 1));
    d_size[d]  = 2'($urandom_range(0, 2));
    d_wstrb[d] = 4'($urandom);
    d_addr[d]  = $urandom;
    d_wdata[d] = $urandom;
  endtask

  // one transaction with immediate handshakes; call at a negedge in IDLE
  task automatic serve(input int d, output int who,
                       output int ai, output int ad,
                       output int di, output int dd);
    @(negedge clk);
    m_aok[d] = 1'b1;
    #1;
    ai = int'(i_aok[d]);
    ad = int'(d_aok[d]);
    @(negedge clk);
    m_aok[d]   = 1'b0;
    m_dok[d]   = 1'b1;
    m_rdata[d] = $urandom;
    #1;
    di = int'(i_dok[d]);
    dd = int'(d_dok[d]);
    @(negedge clk);
    m_dok[d] = 1'b0;
    who = (ad != 0) ? 1 : ((ai != 0) ? 0 : -1);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      i_req[d] = 1'b1;
      d_req[d] = 1'b1;
      m_aok[d] = 1'b1;
      m_dok[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold d=%0d got %b want 00000", d,
                 {m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]});
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b0;
      i_req[d] = 1'b0;
      d_req[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_after d=%0d got %b want 00000", d,
                 {m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]});
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_aok[d] = 1'b0;
      m_dok[d] = 1'b0;
    end
  endtask

  task automatic test_single_fetch();
    int d = 0;
    i_req[d]  = 1'b1;
    i_addr[d] = 32'h1c000000;
    #1;
    checks++;
    if (m_req[d] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_t0_req got %b want 0", m_req[d]);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m_req[d], m_wr[d], m_size[d], m_wstrb[d], m_addr[d], m_wdata[d]}
        !== {1'b1, 1'b0, 2'b10, 4'b0, 32'h1c000000, 32'h0}) begin
      errors++;
      $display("FAIL fetch_t1_bus got req=%b addr=%h size=%b want 1 1c000000 10",
               m_req[d], m_addr[d], m_size[d]);
    end
    @(negedge clk);
    m_aok[d] = 1'b1;
    #1;
    checks++;
    if ({i_aok[d], d_aok[d]} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_t2_aok got %b want 10", {i_aok[d], d_aok[d]});
    end
    @(negedge clk);
    m_aok[d] = 1'b0;
    i_req[d] = 1'b0;
    #1;
    checks++;
    if (m_req[d] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_t3_req got %b want 0", m_req[d]);
    end
    @(negedge clk);
    m_dok[d]   = 1'b1;
    m_rdata[d] = 32'h02800000;
    #1;
    checks++;
    if ({i_dok[d], d_dok[d], i_rdata[d]} !== {2'b10, 32'h02800000}) begin
      errors++;
      $display("FAIL fetch_t4_data got dok=%b rdata=%h want 10 02800000",
               {i_dok[d], d_dok[d]}, i_rdata[d]);
    end
    @(negedge clk);
    m_dok[d] = 1'b0;
    #1;
    checks++;
    if ({m_req[d], i_dok[d]} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_t5_quiet got %b want 00", {m_req[d], i_dok[d]});
    end
  endtask

  task automatic test_tie_fixed();
    int who, ai, ad, di, dd;
    i_req[0] = 1'b1;
    i_addr[0] = 32'h0000_1000;
    raise_data(0);
    serve(0, who, ai, ad, di, dd);
    checks++;
    if ({who, ai, di} !== {32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL tie_fixed_first got who=%0d iaok=%0d idok=%0d want 1 0 0",
               who, ai, di);
    end
    d_req[0] = 1'b0;
    serve(0, who, ai, ad, di, dd);
    checks++;
    if ({who, di, dd} !== {32'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL tie_fixed_second got who=%0d idok=%0d ddok=%0d want 0 1 0",
               who, di, dd);
    end
    i_req[0] = 1'b0;
  endtask

  task automatic test_rr_order();
    int who, ai, ad, di, dd;
    raise_inst(1);
    raise_data(1);
    for (int k = 0; k < 4; k++) begin
      serve(1, who, ai, ad, di, dd);
      checks++;
      if (who !== k % 2) begin
        errors++;
        $display("FAIL rr_order k=%0d got %0d want %0d", k, who, k % 2);
      end
    end
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
  endtask

  task automatic test_store_byte();
    int d = 0;
    d_req[d]   = 1'b1;
    d_wr[d]    = 1'b1;
    d_size[d]  = 2'b00;
    d_wstrb[d] = 4'b0010;
    d_addr[d]  = 32'h1c0f0001;
    d_wdata[d] = 32'h0000_5a00;
    @(negedge clk);
    #1;
    checks++;
    if ({m_req[d], m_wr[d], m_size[d], m_wstrb[d], m_addr[d], m_wdata[d]}
        !== {1'b1, 1'b1, 2'b00, 4'b0010, 32'h1c0f0001, 32'h0000_5a00}) begin
      errors++;
      $display("FAIL store_bus got wr=%b size=%b strb=%b addr=%h wdata=%h",
               m_wr[d], m_size[d], m_wstrb[d], m_addr[d], m_wdata[d]);
    end
    m_aok[d] = 1'b1;
    #1;
    checks++;
    if ({i_aok[d], d_aok[d]} !== 2'b01) begin
      errors++;
      $display("FAIL store_aok got %b want 01", {i_aok[d], d_aok[d]});
    end
    @(negedge clk);
    m_aok[d] = 1'b0;
    d_req[d] = 1'b0;
    m_dok[d] = 1'b1;
    #1;
    checks++;
    if ({i_dok[d], d_dok[d]} !== 2'b01) begin
      errors++;
      $display("FAIL store_dok got %b want 01", {i_dok[d], d_dok[d]});
    end
    @(negedge clk);
    m_dok[d] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d = 1;
    int who, ai, ad, di, dd;
    raise_inst(d);
    @(negedge clk);
    m_aok[d] = 1'b1;
    @(negedge clk);
    m_aok[d] = 1'b0;
    i_req[d] = 1'b0;
    rst[d]   = 1'b1;
    @(negedge clk);
    rst[d]   = 1'b0;
    m_dok[d] = 1'b1;
    #1;
    checks++;
    if ({m_req[d], i_dok[d], d_dok[d]} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_late_dok got %b want 000",
               {m_req[d], i_dok[d], d_dok[d]});
    end
    @(negedge clk);
    m_dok[d] = 1'b0;
    #1;
    checks++;
    if (m_req[d] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle got %b want 0", m_req[d]);
    end
    raise_inst(d);
    raise_data(d);
    serve(d, who, ai, ad, di, dd);
    checks++;
    if ({who, di} !== {32'd0, 32'd1}) begin
      errors++;
      $display("FAIL reset_mid_rr_first got who=%0d idok=%0d want 0 1", who, di);
    end
    i_req[d] = 1'b0;
    d_req[d] = 1'b0;
  endtask

  // model: pending flags per side, grant rule from tie policy and last grant
  task automatic test_random(input int d, input int n);
    bit pi, pd, lg, w;
    int r;
    logic [70:0] exp_bus;
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    lg = 1'b1;
    pi = 1'b0;
    pd = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (!pi && !pd) begin
        r  = $urandom_range(1, 3);
        pi = r[0];
        pd = r[1];
        if (pi) raise_inst(d);
        if (pd) raise_data(d);
      end
      m_dok[d] = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({m_req[d], i_dok[d], d_dok[d]} !== 3'b000) begin
        errors++;
        $display("FAIL rnd_idle d=%0d t=%0d got %b want 000", d, t,
                 {m_req[d], i_dok[d], d_dok[d]});
      end
      w = (pi && pd) ? ((d == 1) ? !lg : 1'b1) : pd;
      exp_bus = w ? {d_wr[d], d_size[d], d_wstrb[d], d_addr[d], d_wdata[d]}
                  : {1'b0, 2'b10, 4'b0000, i_addr[d], 32'h0};
      @(negedge clk);
      m_dok[d] = 1'b0;
      #1;
      checks++;
      if ({m_req[d], m_wr[d], m_size[d], m_wstrb[d], m_addr[d], m_wdata[d]}
          !== {1'b1, exp_bus}) begin
        errors++;
        $display("FAIL rnd_bus d=%0d t=%0d got %b_%h want 1_%h", d, t,
                 m_req[d], {m_wr[d], m_size[d], m_wstrb[d], m_addr[d],
                 m_wdata[d]}, exp_bus);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      m_aok[d] = 1'b1;
      #1;
      checks++;
      if ({i_aok[d], d_aok[d]} !== {!w, w}) begin
        errors++;
        $display("FAIL rnd_aok d=%0d t=%0d got %b want %b", d, t,
                 {i_aok[d], d_aok[d]}, {!w, w});
      end
      @(negedge clk);
      m_aok[d] = 1'($urandom_range(0, 1));
      lg = w;
      if (w) begin
        d_req[d] = 1'b0;
        pd = 1'b0;
        if (!pi && $urandom_range(0, 1) == 1) begin
          pi = 1'b1;
          raise_inst(d);
        end
      end else begin
        i_req[d] = 1'b0;
        pi = 1'b0;
        if (!pd && $urandom_range(0, 1) == 1) begin
          pd = 1'b1;
          raise_data(d);
        end
      end
      #1;
      checks++;
      if ({m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]} !== 5'b0) begin
        errors++;
        $display("FAIL rnd_data_wait d=%0d t=%0d got %b want 00000", d, t,
                 {m_req[d], i_aok[d], d_aok[d], i_dok[d], d_dok[d]});
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      m_aok[d]   = 1'b0;
      m_dok[d]   = 1'b1;
      m_rdata[d] = $urandom;
      #1;
      checks++;
      if ({i_dok[d], d_dok[d], i_rdata[d], d_rdata[d]}
          !== {!w, w, m_rdata[d], m_rdata[d]}) begin
        errors++;
        $display("FAIL rnd_dok d=%0d t=%0d got %b %h %h want %b %h", d, t,
                 {i_dok[d], d_dok[d]}, i_rdata[d], d_rdata[d], {!w, w},
                 m_rdata[d]);
      end
      @(negedge clk);
      m_dok[d] = 1'b0;
    end
    i_req[d] = 1'b0;
    d_req[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]     = 1'b1;
      i_req[d]   = 1'b0;
      i_addr[d]  = 32'h0;
      d_req[d]   = 1'b0;
      d_wr[d]    = 1'b0;
      d_size[d]  = 2'b0;
      d_wstrb[d] = 4'b0;
      d_addr[d]  = 32'h0;
      d_wdata[d] = 32'h0;
      m_aok[d]   = 1'b0;
      m_dok[d]   = 1'b0;
      m_rdata[d] = 32'h0;
    end
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_tie_fixed();
    test_rr_order();
    test_store_byte();
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
